// File: rtl/aes_block_loader.sv
// Handshaked input stage for the AES core: collects 128-bit state and key from a word stream.
// Optional watchdog in BUSY enabled by defining AES_LOADER_TIMEOUT_EN.
module aes_block_loader #(
   parameter int WORD_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_sel,
   output logic [127:0]      out_state,
   output logic [127:0]      out_key,
   output logic              start,
   input  logic              core_done,
   output logic              key_valid,
   output logic [15:0]       blk_cnt,
   output logic              err
);

   localparam int N_WORDS = 128 / WORD_W;
   localparam int CW      = $clog2(N_WORDS);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_WORDS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_PEND    = 2'd1,
      ST_START   = 2'd2,
      ST_BUSY    = 2'd3
   } fsm_t;

   fsm_t           state_r;
   fsm_t           state_nxt_s;
   logic           rdy_en_r;
   logic           ready_s;
   logic           accept_s;
   logic           st_acc_s;
   logic           key_acc_s;
   logic           st_last_s;
   logic           key_last_s;
   logic [127:0]   st_shift_s;
   logic [127:0]   key_shift_s;
   logic [127:0]   st_shadow_r;
   logic [127:0]   key_shadow_r;
   logic [127:0]   out_state_r;
   logic [127:0]   out_key_r;
   logic [CW-1:0]  st_cnt_r;
   logic [CW-1:0]  key_cnt_r;
   logic           key_valid_r;
   logic           start_r;
   logic [15:0]    blk_cnt_r;

   // rdy_en_r keeps in_ready low while reset is held and releases it one edge later
   // Word acceptance depends only on FSM state and the word type on offer
   always_comb begin
      ready_s = 1'b0;
      if (rdy_en_r) begin
         case (state_r)
            ST_COLLECT: ready_s = 1'b1;
            ST_PEND:    ready_s = in_sel;
            default:    ready_s = 1'b0;
         endcase
      end else begin
         ready_s = 1'b0;
      end
   end

   assign in_ready    = ready_s;
   assign accept_s    = in_valid && ready_s;
   assign st_acc_s    = accept_s && !in_sel;
   assign key_acc_s   = accept_s && in_sel;
   assign st_last_s   = st_acc_s && (st_cnt_r == LAST_IDX);
   assign key_last_s  = key_acc_s && (key_cnt_r == LAST_IDX);
   assign st_shift_s  = {st_shadow_r[127-WORD_W:0], in_data};
   assign key_shift_s = {key_shadow_r[127-WORD_W:0], in_data};

`ifdef AES_LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   logic [TW-1:0] tmo_cnt_r;
   logic          tmo_hit_s;
   logic          err_r;

   // The limit is hit during the TIMEOUT_CYCLES-th BUSY cycle
   assign tmo_hit_s = (state_r == ST_BUSY) && (tmo_cnt_r == TMO_LAST);

   // Watchdog counter: cleared on BUSY entry, counts BUSY cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt_r <= '0;
         err_r     <= 1'b0;
      end else begin
         if (state_r == ST_START) begin
            tmo_cnt_r <= '0;
         end else if (state_r == ST_BUSY) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
         end
         err_r <= tmo_hit_s && !core_done;
      end
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   // Next-state logic; core_done only matters in BUSY
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_COLLECT: begin
            if (st_last_s) begin
               state_nxt_s = key_valid_r ? ST_START : ST_PEND;
            end else begin
               state_nxt_s = ST_COLLECT;
            end
         end
         ST_PEND: begin
            if (key_last_s || key_valid_r) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_PEND;
            end
         end
         ST_START: state_nxt_s = ST_BUSY;
         ST_BUSY: begin
            if (core_done) begin
               state_nxt_s = ST_COLLECT;
`ifdef AES_LOADER_TIMEOUT_EN
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_COLLECT;
`endif
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         default: state_nxt_s = ST_COLLECT;
      endcase
   end

   // FSM state, launch pulse and launch counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_COLLECT;
         rdy_en_r  <= 1'b0;
         start_r   <= 1'b0;
         blk_cnt_r <= 16'd0;
      end else begin
         state_r  <= state_nxt_s;
         rdy_en_r <= 1'b1;
         start_r  <= (state_nxt_s == ST_START);
         if (state_nxt_s == ST_START) begin
            blk_cnt_r <= blk_cnt_r + 16'd1;
         end
      end
   end

   // State shadow and commit
   always_ff @(posedge clk) begin
      if (!rst) begin
         st_shadow_r <= 128'd0;
         out_state_r <= 128'd0;
         st_cnt_r    <= '0;
      end else if (st_acc_s) begin
         st_shadow_r <= st_shift_s;
         if (st_last_s) begin
            out_state_r <= st_shift_s;
            st_cnt_r    <= '0;
         end else begin
            st_cnt_r <= st_cnt_r + CNT_ONE;
         end
      end
   end

   // Key shadow and commit; a new key invalidates the old one from its first word
   always_ff @(posedge clk) begin
      if (!rst) begin
         key_shadow_r <= 128'd0;
         out_key_r    <= 128'd0;
         key_cnt_r    <= '0;
         key_valid_r  <= 1'b0;
      end else if (key_acc_s) begin
         key_shadow_r <= key_shift_s;
         if (key_last_s) begin
            out_key_r   <= key_shift_s;
            key_cnt_r   <= '0;
            key_valid_r <= 1'b1;
         end else begin
            key_cnt_r <= key_cnt_r + CNT_ONE;
            if (key_cnt_r == '0) begin
               key_valid_r <= 1'b0;
            end
         end
      end
   end

   assign out_state = out_state_r;
   assign out_key   = out_key_r;
   assign start     = start_r;
   assign key_valid = key_valid_r;
   assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader (WORD_W = 32, TIMEOUT_CYCLES = 8).
module tb_aes_block_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_sel;
   logic [127:0] out_state;
   logic [127:0] out_key;
   logic         start;
   logic         core_done;
   logic         key_valid;
   logic [15:0]  blk_cnt;
   logic         err;

   int total = 0;
   int bad   = 0;
   int exp_blk = 0;

   logic [127:0] key_a   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
   logic [127:0] state_a = 128'h3243F6A8885A308D313198A2E0370734;
   logic [127:0] key_b   = 128'h000102030405060708090A0B0C0D0E0F;
   logic [127:0] state_b = 128'h00112233445566778899AABBCCDDEEFF;
   logic [127:0] state_c = 128'hCAFEF00D0123456789ABCDEF13579BDF;

   aes_block_loader #(.WORD_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_state (out_state),
      .out_key   (out_key),
      .start     (start),
      .core_done (core_done),
      .key_valid (key_valid),
      .blk_cnt   (blk_cnt),
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog sim time limit total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and return just after the edge that accepted it
   task automatic send_word(input logic sel, input logic [31:0] d);
      int guard = 0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = d;
      #1;
      while (!in_ready && guard < 60) begin
         step();
         guard++;
      end
      if (!in_ready) begin
         chk("ready_wait", {127'd0, in_ready}, 128'd1);
      end else begin
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic send_blk(input logic sel, input logic [127:0] blk);
      for (int i = 0; i < 4; i++) begin
         send_word(sel, blk[127-32*i -: 32]);
      end
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 1'b0;
      in_data   = 32'hDEADBEEF;
      core_done = 1'b0;
      repeat (2) step();
      chk("rst_ready", {127'd0, in_ready}, 128'd0);
      chk("rst_state", out_state, 128'd0);
      chk("rst_key", out_key, 128'd0);
      chk("rst_start", {127'd0, start}, 128'd0);
      chk("rst_kvalid", {127'd0, key_valid}, 128'd0);
      chk("rst_blkcnt", {112'd0, blk_cnt}, 128'd0);
      chk("rst_err", {127'd0, err}, 128'd0);
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      chk("rel_ready", {127'd0, in_ready}, 128'd1);

      // Key load then state load with key already valid
      for (int i = 0; i < 4; i++) begin
         send_word(1'b1, key_a[127-32*i -: 32]);
         if (i == 2) chk("kv_partial", {127'd0, key_valid}, 128'd0);
      end
      chk("key_a", out_key, key_a);
      chk("kv_set", {127'd0, key_valid}, 128'd1);
      chk("no_start_key", {127'd0, start}, 128'd0);
      send_blk(1'b0, state_a);
      exp_blk++;
      chk("state_a", out_state, state_a);
      chk("start_hi", {127'd0, start}, 128'd1);
      chk("blk_1", {112'd0, blk_cnt}, 128'(exp_blk));
      chk("ready_start", {127'd0, in_ready}, 128'd0);
      step();
      chk("start_lo", {127'd0, start}, 128'd0);

      // Backpressure through BUSY
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'hFFFFFFFF;
      repeat (20) step();
      chk("busy_ready", {127'd0, in_ready}, 128'd0);
      chk("busy_state", out_state, state_a);
      chk("busy_key", out_key, key_a);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      chk("done_ready", {127'd0, in_ready}, 128'd1);
      in_valid = 1'b0;
      chk("done_blk", {112'd0, blk_cnt}, 128'(exp_blk));

      // Key reload clears key_valid, state completes first -> PEND
      send_word(1'b1, key_b[127:96]);
      chk("reload_kv", {127'd0, key_valid}, 128'd0);
      send_blk(1'b0, state_b);
      chk("pend_state", out_state, state_b);
      chk("pend_nostart", {127'd0, start}, 128'd0);
      in_sel = 1'b0;
      #1;
      chk("pend_rdy_st", {127'd0, in_ready}, 128'd0);
      in_sel = 1'b1;
      #1;
      chk("pend_rdy_key", {127'd0, in_ready}, 128'd1);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      chk("pend_done_ign", {127'd0, start}, 128'd0);
      in_sel = 1'b0;
      #1;
      chk("pend_hold", {127'd0, in_ready}, 128'd0);
      for (int i = 1; i < 4; i++) send_word(1'b1, key_b[127-32*i -: 32]);
      exp_blk++;
      chk("key_b", out_key, key_b);
      chk("pend_start", {127'd0, start}, 128'd1);
      chk("blk_2", {112'd0, blk_cnt}, 128'(exp_blk));
      core_done = 1'b1;
      step();
      step();
      core_done = 1'b0;
      chk("pend_back", {127'd0, in_ready}, 128'd1);

      // Reset mid-block discards partial words; then state before key
      send_word(1'b0, 32'h11111111);
      send_word(1'b0, 32'h22222222);
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_blk", {112'd0, blk_cnt}, 128'd0);
      chk("mid_rst_kv", {127'd0, key_valid}, 128'd0);
      exp_blk = 0;
      send_blk(1'b0, state_c);
      chk("nokey_state", out_state, state_c);
      chk("nokey_start", {127'd0, start}, 128'd0);
      send_blk(1'b1, key_a);
      exp_blk++;
      chk("nokey_launch", {127'd0, start}, 128'd1);
      chk("nokey_blk", {112'd0, blk_cnt}, 128'(exp_blk));
      core_done = 1'b1;
      step();
      step();
      core_done = 1'b0;

`ifdef AES_LOADER_TIMEOUT_EN
      // Watchdog fires 8 cycles after BUSY entry
      send_blk(1'b0, state_a);
      exp_blk++;
      repeat (8) step();
      chk("tmo_pre_err", {127'd0, err}, 128'd0);
      chk("tmo_pre_rdy", {127'd0, in_ready}, 128'd0);
      step();
      chk("tmo_err", {127'd0, err}, 128'd1);
      chk("tmo_ready", {127'd0, in_ready}, 128'd1);
      chk("tmo_blk", {112'd0, blk_cnt}, 128'(exp_blk));
      step();
      chk("tmo_err_lo", {127'd0, err}, 128'd0);
      // done on the limit cycle wins
      send_blk(1'b0, state_b);
      exp_blk++;
      repeat (8) step();
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      chk("tmo_done_err", {127'd0, err}, 128'd0);
      chk("tmo_done_rdy", {127'd0, in_ready}, 128'd1);
`else
      // Without the watchdog BUSY waits for core_done indefinitely
      send_blk(1'b0, state_a);
      exp_blk++;
      repeat (100) step();
      chk("nowd_err", {127'd0, err}, 128'd0);
      chk("nowd_busy", {127'd0, in_ready}, 128'd0);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      chk("nowd_ready", {127'd0, in_ready}, 128'd1);
`endif

      // Back-to-back launches with core_done held high
      core_done = 1'b1;
      for (int b = 0; b < 40; b++) begin
         send_blk(1'b0, {state_c[127:32], 32'(b)});
      end
      exp_blk += 40;
      repeat (3) step();
      core_done = 1'b0;
      chk("burst_blk", {112'd0, blk_cnt}, 128'(exp_blk));
      chk("burst_state", out_state, {state_c[127:32], 32'd39});
      chk("burst_ready", {127'd0, in_ready}, 128'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
